// File: rtl/rf_pkg.sv
// Shared register-file writeback types and constants.
package rf_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              valid;
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_tag_fifo.sv
// In-order destination-tag FIFO for outstanding loads; extra pointer bit separates full from empty.
module rf_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback arbiter: load responses beat ALU results, scoreboard blocks RAW/WAW on pending loads.
// Optional macro RF_WB_BYPASS_EN adds combinational byp_* forwarding outputs.
module rf_wb_ctrl #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_W    = 5,
    parameter int unsigned LD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [REG_W-1:0]  ld_reg,
    output logic              ld_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [REG_W-1:0]  query_reg1,
    input  logic [REG_W-1:0]  query_reg2,
    output logic              busy1,
    output logic              busy2,
    output logic              write,
    output logic [REG_W-1:0]  write_reg,
    output logic [DATA_W-1:0] write_data
`ifdef RF_WB_BYPASS_EN
    ,
    output logic              byp_valid,
    output logic [REG_W-1:0]  byp_reg,
    output logic [DATA_W-1:0] byp_data
`endif
);

    import rf_pkg::*;

    localparam int unsigned NREG = 1 << REG_W;
    localparam int unsigned CW   = $clog2(LD_DEPTH + 1);

    logic [REG_W-1:0] head_reg;
    logic             fifo_full;
    logic             fifo_empty;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    ld_cnt [NREG];
    logic [NREG-1:0]  busy_vec;
    wb_req_t          win;

    assign ld_ready  = !fifo_full;
    assign do_push   = ld_issue && ld_ready;
    assign do_pop    = mem_rvalid && !fifo_empty;
    assign alu_ready = alu_valid && !mem_rvalid && !busy_vec[alu_reg];
    assign busy1     = busy_vec[query_reg1];
    assign busy2     = busy_vec[query_reg2];

    rf_tag_fifo #(
        .DEPTH (LD_DEPTH),
        .W     (REG_W)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .din   (ld_reg),
        .pop   (do_pop),
        .dout  (head_reg),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Per-register outstanding-load counts; register 0 is never counted so it never reads busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) ld_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < int'(NREG); r++) begin
                if ((do_push && ld_reg == REG_W'(r) && ld_reg != REG_ZERO) &&
                    !(do_pop && head_reg == REG_W'(r)))
                    ld_cnt[r] <= ld_cnt[r] + CW'(1);
                else if (!(do_push && ld_reg == REG_W'(r) && ld_reg != REG_ZERO) &&
                         (do_pop && head_reg == REG_W'(r) && head_reg != REG_ZERO))
                    ld_cnt[r] <= ld_cnt[r] - CW'(1);
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < int'(NREG); r++) busy_vec[r] = (ld_cnt[r] != '0);
    end

    // Winning write this cycle; a valid bit is suppressed for register 0.
    always_comb begin
        win = '0;
        if (do_pop) begin
            win.valid = (head_reg != REG_ZERO);
            win.dst   = head_reg;
            win.data  = mem_rdata;
        end else if (alu_ready) begin
            win.valid = (alu_reg != REG_ZERO);
            win.dst   = alu_reg;
            win.data  = alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write      <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            write <= win.valid;
            if (win.valid) begin
                write_reg  <= win.dst;
                write_data <= win.data;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign byp_valid = win.valid;
    assign byp_reg   = win.dst;
    assign byp_data  = win.data;
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed scenarios with literal expectations plus randomized traffic against a queue model.
module tb_rf_wb_ctrl;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned LD_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_valid;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              ld_issue;
    logic [REG_W-1:0]  ld_reg;
    logic              ld_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_W-1:0]  query_reg1;
    logic [REG_W-1:0]  query_reg2;
    logic              busy1;
    logic              busy2;
    logic              write;
    logic [REG_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
`ifdef RF_WB_BYPASS_EN
    logic              byp_valid;
    logic [REG_W-1:0]  byp_reg;
    logic [DATA_W-1:0] byp_data;
`endif

    rf_wb_ctrl #(
        .DATA_W   (DATA_W),
        .REG_W    (REG_W),
        .LD_DEPTH (LD_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .ld_issue   (ld_issue),
        .ld_reg     (ld_reg),
        .ld_ready   (ld_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .query_reg1 (query_reg1),
        .query_reg2 (query_reg2),
        .busy1      (busy1),
        .busy2      (busy2),
        .write      (write),
        .write_reg  (write_reg),
        .write_data (write_data)
`ifdef RF_WB_BYPASS_EN
        ,
        .byp_valid  (byp_valid),
        .byp_reg    (byp_reg),
        .byp_data   (byp_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wcount = 0;

    // Model state: tags of outstanding loads in issue order, and the expected registered outputs.
    int          q[$];
    logic        exp_w;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic bit m_busy(int r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle();
        rst = 0; alu_valid = 0; ld_issue = 0; mem_rvalid = 0;
    endtask

    // One clock: check combinational outputs, advance the model, then check registered outputs.
    task automatic step();
        bit pop_ok, push_ok, aready, win_v;
        int win_r;
        logic [31:0] win_d;
        #2;
        aready  = alu_valid && !mem_rvalid && !m_busy(int'(alu_reg));
        pop_ok  = mem_rvalid && (q.size() > 0);
        push_ok = ld_issue && (q.size() < LD_DEPTH);
        chk("ld_ready", 32'(ld_ready), 32'(q.size() < LD_DEPTH));
        chk("alu_ready", 32'(alu_ready), 32'(aready));
        chk("busy1", 32'(busy1), 32'(m_busy(int'(query_reg1))));
        chk("busy2", 32'(busy2), 32'(m_busy(int'(query_reg2))));
        win_v = 0; win_r = 0; win_d = '0;
        if (pop_ok) begin
            win_r = q[0]; win_d = mem_rdata; win_v = (win_r != 0);
        end else if (aready) begin
            win_r = int'(alu_reg); win_d = alu_data; win_v = (win_r != 0);
        end
`ifdef RF_WB_BYPASS_EN
        chk("byp_valid", 32'(byp_valid), 32'(win_v));
        if (win_v) begin
            chk("byp_reg", 32'(byp_reg), 32'(win_r));
            chk("byp_data", byp_data, win_d);
        end
`endif
        if (rst) begin
            q.delete();
            exp_w = 0; exp_wr = '0; exp_wd = '0;
        end else begin
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back(int'(ld_reg));
            exp_w = win_v;
            if (win_v) begin exp_wr = 5'(win_r); exp_wd = win_d; end
        end
        @(posedge clk);
        #1;
        chk("write", 32'(write), 32'(exp_w));
        chk("write_reg", 32'(write_reg), 32'(exp_wr));
        chk("write_data", write_data, exp_wd);
        if (write === 1'b1) wcount++;
    endtask

    task automatic do_alu(int r, logic [31:0] d);
        idle(); alu_valid = 1; alu_reg = 5'(r); alu_data = d;
    endtask

    task automatic do_ld(int r);
        idle(); ld_issue = 1; ld_reg = 5'(r);
    endtask

    task automatic do_resp(logic [31:0] d);
        idle(); mem_rvalid = 1; mem_rdata = d;
    endtask

    initial begin
        idle();
        rst = 1; alu_reg = '0; alu_data = '0; ld_reg = '0; mem_rdata = '0;
        query_reg1 = '0; query_reg2 = '0;
        exp_w = 0; exp_wr = '0; exp_wd = '0;
        @(posedge clk); #1;
        rst = 1; step(); rst = 1; step();
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        idle(); #1;
        chk("rst_ld_ready", 32'(ld_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);

        // ALU write to r3
        do_alu(3, 32'hDEADBEEF); #1;
        chk("alu3_ready", 32'(alu_ready), 32'd1);
        step();
        chk("alu3_write", 32'(write), 32'd1);
        chk("alu3_reg", 32'(write_reg), 32'd3);
        chk("alu3_data", write_data, 32'hDEADBEEF);
        idle(); step();
        chk("alu3_pulse_end", 32'(write), 32'd0);
        chk("alu3_hold_reg", 32'(write_reg), 32'd3);

        // Load to r5 with three-cycle return
        do_ld(5); query_reg1 = 5; step();
        idle(); #1;
        chk("ld5_busy", 32'(busy1), 32'd1);
        step(); idle(); step();
        do_resp(32'h1234); step();
        chk("ld5_write", 32'(write), 32'd1);
        chk("ld5_reg", 32'(write_reg), 32'd5);
        chk("ld5_data", write_data, 32'h1234);
        idle(); #1;
        chk("ld5_busy_clear", 32'(busy1), 32'd0);

        // Two loads to r7
        query_reg1 = 7;
        do_ld(7); step(); do_ld(7); step();
        do_resp(32'hA); step();
        chk("ld7_first_data", write_data, 32'hA);
        idle(); #1;
        chk("ld7_still_busy", 32'(busy1), 32'd1);
        do_resp(32'hB); step();
        chk("ld7_second_data", write_data, 32'hB);
        idle(); #1;
        chk("ld7_busy_clear", 32'(busy1), 32'd0);

        // Load response beats ALU
        do_ld(2); step();
        do_resp(32'h22); alu_valid = 1; alu_reg = 9; alu_data = 32'h99; #1;
        chk("arb_alu_blocked", 32'(alu_ready), 32'd0);
        step();
        chk("arb_first_reg", 32'(write_reg), 32'd2);
        mem_rvalid = 0; #1;
        chk("arb_alu_ready", 32'(alu_ready), 32'd1);
        step();
        chk("arb_second_reg", 32'(write_reg), 32'd9);
        chk("arb_second_write", 32'(write), 32'd1);

        // Fill the FIFO, overflow attempt, drain
        for (int i = 0; i < 4; i++) begin do_ld(10 + i); step(); end
        idle(); #1;
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        do_ld(6); step();
        wcount = 0;
        for (int i = 0; i < 4; i++) begin do_resp(32'h100 + 32'(i)); step(); end
        chk("drain_writes", 32'(wcount), 32'd4);
        chk("drain_last_reg", 32'(write_reg), 32'd13);
        idle(); query_reg2 = 6; #1;
        chk("drain_ld_ready", 32'(ld_ready), 32'd1);
        chk("overflow_not_busy", 32'(busy2), 32'd0);

        // Register 0 targets
        do_alu(0, 32'h55); #1;
        chk("r0_alu_ready", 32'(alu_ready), 32'd1);
        step();
        chk("r0_alu_no_write", 32'(write), 32'd0);
        do_ld(0); step();
        do_resp(32'h66); step();
        chk("r0_ld_no_write", 32'(write), 32'd0);
        idle(); #1;
        chk("r0_fifo_empty", 32'(ld_ready), 32'd1);

        // Reset with loads in flight, then a stray response
        query_reg1 = 14; query_reg2 = 15;
        do_ld(14); step(); do_ld(15); step();
        do_alu(20, 32'h77); step();
        idle(); rst = 1; step();
        chk("mid_rst_write", 32'(write), 32'd0);
        idle(); #1;
        chk("mid_rst_busy1", 32'(busy1), 32'd0);
        chk("mid_rst_busy2", 32'(busy2), 32'd0);
        chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
        do_resp(32'hBAD); step();
        chk("stray_no_write", 32'(write), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 199) == 0);
            alu_valid  = 1'($urandom_range(0, 1));
            alu_reg    = 5'($urandom_range(0, 7));
            alu_data   = $urandom;
            ld_issue   = ($urandom_range(0, 2) == 0);
            ld_reg     = 5'($urandom_range(0, 7));
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            query_reg1 = 5'($urandom_range(0, 7));
            query_reg2 = 5'($urandom_range(0, 7));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Writeback controller that drives the single write port of the 32×32 MIPS register file. It merges single-cycle ALU results with in-order, variable-latency load responses and tracks registers with outstanding loads in a scoreboard. It exposes per-register busy status so decode can stall on RAW hazards.

## Interface
Parameters:
- DATA_W, 32, register data width
- REG_W, 5, register index width
- LD_DEPTH, 4, max outstanding loads; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_reg  in  REG_W  ALU destination
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU result accepted this cycle
- ld_issue  in  1  load issued to memory
- ld_reg  in  REG_W  load destination
- ld_ready  out  1  load tag FIFO can accept
- mem_rvalid  in  1  load data returned, in issue order
- mem_rdata  in  DATA_W  load data
- query_reg1, query_reg2  in  REG_W  decode source registers
- busy1, busy2  out  1  source register has an outstanding load
- write  out  1  register file write enable
- write_reg  out  REG_W  register file write index
- write_data  out  DATA_W  register file write data

## Operation
- Load tag FIFO: LD_DEPTH entries of REG_W. Push on ld_issue && ld_ready. Pop on mem_rvalid. ld_ready = !full.
- mem_rvalid with an empty FIFO is a protocol error. It is ignored: no pop, no write.
- ld_issue while full is ignored, with no side effects.
- Scoreboard: busy[r] = some FIFO entry holds r. Compute it as a per-register count or a FIFO scan; either is acceptable. Register 0 is never busy.
- busy1/busy2 are combinational from the scoreboard and do not reflect a push in the same cycle.
- Arbitration, evaluated each cycle:
  - Load response wins. It writes head-tag register ← mem_rdata.
  - Otherwise, ALU is accepted when alu_valid && !busy[alu_reg]. The busy check enforces WAW ordering behind pending loads.
  - alu_ready = alu_valid && !mem_rvalid && !busy[alu_reg] (with busy[0] = 0).
- Destination register 0: the transaction completes (handshake and pop) but write stays 0.
- Outputs are registered. The winning transaction appears on write/write_reg/write_data on the next cycle. write is high for exactly one cycle per accepted non-zero write.
- write_reg and write_data hold their last values when write = 0.

## Timing
- Reset values:
  - write = 0, write_reg = 0, write_data = 0
  - FIFO empty, all scoreboard bits clear
  - ld_ready = 1, alu_ready = 0
- Latency from accept to write asserted: 1 cycle. The register file captures the value at the following edge.
- Simultaneous push and pop at full: legal only if the FIFO is not full before the push. The push is gated by ld_ready, which is sampled before the pop.
- Simultaneous push and pop at empty: the pop is ignored and the push is stored.
- Same-cycle ld_issue to r and ALU write to r: the ALU write is accepted, because busy is still clear, and is ordered before the load.
- Read/write pointers wrap modulo LD_DEPTH. Full and empty are distinguished by an extra pointer bit.
- Reset asserted mid-operation: all outstanding tags are discarded and the pending write is cleared on the next edge. Late mem_rvalid beats after reset are ignored, since the FIFO is empty.

## Configuration
- RF_WB_BYPASS_EN defined:
  - Adds outputs byp_valid (1), byp_reg (REG_W) and byp_data (DATA_W), combinational from the winning transaction this cycle.
  - byp_valid = 0 for register 0.
  - Decode may forward one cycle earlier than write.
- RF_WB_BYPASS_EN undefined: these ports are absent. Behaviour is otherwise identical.

## Structure
- Shared package rf_pkg holds:
  - REG_W and DATA_W constants
  - The REG_ZERO constant (5'd0)
  - A wb_req_t struct {valid, reg, data} used for the internal arbitration result and the bypass bundle
- One sub-module: rf_tag_fifo (LD_DEPTH × REG_W, push/pop/full/empty). The scoreboard stays in rf_wb_ctrl.

## Test plan
- Reset, then ALU write with alu_reg=3, alu_data=0xDEADBEEF → alu_ready=1. Next cycle: write=1, write_reg=3, write_data=0xDEADBEEF, for exactly one cycle.
- ld_issue ld_reg=5 → busy1=1 for query_reg1=5. Three cycles later, mem_rvalid with rdata=0x1234 → next cycle write reg 5 = 0x1234, and busy1 = 0 from that same cycle.
- Issue loads to 7 and 7 → busy[7] stays 1 after the first response and clears only after the second. Responses are written in issue order.
- ALU write to 9 in the same cycle as mem_rvalid for a load to 2 → load written first. alu_ready=0 that cycle; ALU accepted the next cycle, giving consecutive writes 2 then 9.
- Issue 4 loads → ld_ready=0 and a fifth ld_issue is ignored. After 4 responses: empty, ld_ready=1, 4 writes observed. ALU and load writes to reg 0 → no write pulse, and the handshake still completes.
- Two loads outstanding, then rst asserted for one cycle → write=0, busy all 0, ld_ready=1. A subsequent stray mem_rvalid produces no write.
